// File: rtl/altera_ddr_ex_rd_checker_if.sv
// Read-check bus between the DDR example driver's read path, its per-lane
// LFSR pattern generators and the read-data checker.
interface altera_ddr_ex_rd_checker_if #(
   parameter int DWIDTH = 16,
   parameter int CWIDTH = 16
);
   localparam int NBYTES = DWIDTH / 8;

   logic              start;
   logic [CWIDTH-1:0] expected_beats;
   logic              rd_valid;
   logic [DWIDTH-1:0] rd_data;
   logic [DWIDTH-1:0] exp_data;
   logic              lfsr_enable;
   logic              lfsr_pause;
   logic              busy;
   logic              done;
   logic [NBYTES-1:0] pnf_per_byte;
   logic              pnf;
   logic [CWIDTH-1:0] err_count;
   logic              first_err_valid;
   logic [CWIDTH-1:0] first_err_beat;
   logic              overrun;

   // Checker side: consumes read beats and expected pattern, reports results.
   modport slave (
      input  start, expected_beats, rd_valid, rd_data, exp_data,
      output lfsr_enable, lfsr_pause, busy, done, pnf_per_byte, pnf,
             err_count, first_err_valid, first_err_beat, overrun
   );

   // Driver side: issues runs, supplies read data and generator output.
   modport master (
      output start, expected_beats, rd_valid, rd_data, exp_data,
      input  lfsr_enable, lfsr_pause, busy, done, pnf_per_byte, pnf,
             err_count, first_err_valid, first_err_beat, overrun
   );
endinterface

// File: rtl/altera_ddr_ex_rd_checker.sv
// Read-data checker for the DDR example driver. Steps the per-lane LFSR
// generators once per accepted read beat, compares each beat against the
// generator output through a two-stage pipeline and accumulates per-lane
// pass/not-fail, a saturating error count and the first failing beat index.
module altera_ddr_ex_rd_checker #(
   parameter int DWIDTH = 16,
   parameter int CWIDTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   altera_ddr_ex_rd_checker_if.slave    bus
);
   localparam int NBYTES = DWIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              drain_cnt_q, drain_cnt_d;

   logic [CWIDTH-1:0] beats_q, beats_d;
   logic [CWIDTH-1:0] beat_cnt_q, beat_cnt_d;

   // Compare stage 1: per-lane mismatch of the accepted beat and its index.
   logic              s1_valid_q, s1_valid_d;
   logic [NBYTES-1:0] s1_mis_q, s1_mis_d;
   logic [CWIDTH-1:0] s1_beat_q, s1_beat_d;

   // Compare stage 2: accumulated run results.
   logic [NBYTES-1:0] pnf_per_byte_q, pnf_per_byte_d;
   logic              pnf_q, pnf_d;
   logic [CWIDTH-1:0] err_count_q, err_count_d;
   logic              first_err_valid_q, first_err_valid_d;
   logic [CWIDTH-1:0] first_err_beat_q, first_err_beat_d;
   logic              overrun_q, overrun_d;

   logic              idle_like_s;
   logic              run_start_s;
   logic              accept_s;
   logic              last_beat_s;
   logic [NBYTES-1:0] mis_s;

   logic              lfsr_enable_s;
   logic              lfsr_pause_s;
   logic              busy_s;
   logic              done_s;

   // Decode of run start, beat acceptance and last-beat detection.
   always_comb begin
      idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
      run_start_s = bus.start && idle_like_s;
      accept_s    = (state_q == ST_CHECK) && bus.rd_valid;
      last_beat_s = accept_s && (beat_cnt_q == (beats_q - CWIDTH'(1)));
   end

   // Per-lane mismatch between the read beat and the generator output.
   always_comb begin
      mis_s = {NBYTES{1'b0}};
      for (int i = 0; i < NBYTES; i++) begin
         mis_s[i] = |(bus.rd_data[8*i +: 8] ^ bus.exp_data[8*i +: 8]);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         drain_cnt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // FSM next state: a zero-length run goes straight to DONE; DRAIN lasts two cycles.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (run_start_s) begin
               if (bus.expected_beats == CWIDTH'(0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CHECK;
               end
            end else begin
               state_d = state_q;
            end
            drain_cnt_d = 1'b0;
         end
         ST_CHECK: begin
            if (last_beat_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_CHECK;
            end
            drain_cnt_d = 1'b0;
         end
         ST_DRAIN: begin
            if (drain_cnt_q) begin
               state_d     = ST_DONE;
               drain_cnt_d = 1'b0;
            end else begin
               state_d     = ST_DRAIN;
               drain_cnt_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            drain_cnt_d = 1'b0;
         end
      endcase
   end

   // FSM outputs: generators run only during a run and step only on an accepted beat.
   always_comb begin
      lfsr_enable_s = 1'b0;
      busy_s        = 1'b0;
      done_s        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            lfsr_enable_s = 1'b0;
            busy_s        = 1'b0;
            done_s        = 1'b0;
         end
         ST_CHECK, ST_DRAIN: begin
            lfsr_enable_s = 1'b1;
            busy_s        = 1'b1;
            done_s        = 1'b0;
         end
         ST_DONE: begin
            lfsr_enable_s = 1'b0;
            busy_s        = 1'b0;
            done_s        = 1'b1;
         end
         default: begin
            lfsr_enable_s = 1'b0;
            busy_s        = 1'b0;
            done_s        = 1'b0;
         end
      endcase
      lfsr_pause_s = !accept_s;
   end

   // Beat counter, run length latch and compare stage 1 next values.
   always_comb begin
      beats_d    = beats_q;
      beat_cnt_d = beat_cnt_q;
      s1_valid_d = accept_s;
      s1_mis_d   = mis_s;
      s1_beat_d  = beat_cnt_q;
      if (run_start_s) begin
         beats_d    = bus.expected_beats;
         beat_cnt_d = CWIDTH'(0);
      end else if (accept_s) begin
         beats_d    = beats_q;
         beat_cnt_d = beat_cnt_q + CWIDTH'(1);
      end else begin
         beats_d    = beats_q;
         beat_cnt_d = beat_cnt_q;
      end
   end

   // Compare stage 2: sticky lane PNF, saturating error count, first-error capture.
   always_comb begin
      pnf_per_byte_d    = pnf_per_byte_q;
      err_count_d       = err_count_q;
      first_err_valid_d = first_err_valid_q;
      first_err_beat_d  = first_err_beat_q;
      overrun_d         = overrun_q;
      if (run_start_s) begin
         pnf_per_byte_d    = {NBYTES{1'b1}};
         err_count_d       = CWIDTH'(0);
         first_err_valid_d = 1'b0;
         first_err_beat_d  = CWIDTH'(0);
         // A beat arriving alongside start is still unsolicited.
         overrun_d         = bus.rd_valid;
      end else begin
         if (s1_valid_q && (|s1_mis_q)) begin
            pnf_per_byte_d = pnf_per_byte_q & ~s1_mis_q;
            if (err_count_q != {CWIDTH{1'b1}}) begin
               err_count_d = err_count_q + CWIDTH'(1);
            end else begin
               err_count_d = err_count_q;
            end
            if (!first_err_valid_q) begin
               first_err_valid_d = 1'b1;
               first_err_beat_d  = s1_beat_q;
            end else begin
               first_err_valid_d = first_err_valid_q;
               first_err_beat_d  = first_err_beat_q;
            end
         end else begin
            pnf_per_byte_d = pnf_per_byte_q;
            err_count_d    = err_count_q;
         end
         if (idle_like_s && bus.rd_valid) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end
      pnf_d = &pnf_per_byte_d;
   end

   // Datapath registers: counters, compare pipeline and result flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         beats_q           <= CWIDTH'(0);
         beat_cnt_q        <= CWIDTH'(0);
         s1_valid_q        <= 1'b0;
         s1_mis_q          <= {NBYTES{1'b0}};
         s1_beat_q         <= CWIDTH'(0);
         pnf_per_byte_q    <= {NBYTES{1'b1}};
         pnf_q             <= 1'b1;
         err_count_q       <= CWIDTH'(0);
         first_err_valid_q <= 1'b0;
         first_err_beat_q  <= CWIDTH'(0);
         overrun_q         <= 1'b0;
      end else begin
         beats_q           <= beats_d;
         beat_cnt_q        <= beat_cnt_d;
         s1_valid_q        <= s1_valid_d;
         s1_mis_q          <= s1_mis_d;
         s1_beat_q         <= s1_beat_d;
         pnf_per_byte_q    <= pnf_per_byte_d;
         pnf_q             <= pnf_d;
         err_count_q       <= err_count_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_beat_q  <= first_err_beat_d;
         overrun_q         <= overrun_d;
      end
   end

   assign bus.lfsr_enable     = lfsr_enable_s;
   assign bus.lfsr_pause      = lfsr_pause_s;
   assign bus.busy            = busy_s;
   assign bus.done            = done_s;
   assign bus.pnf_per_byte    = pnf_per_byte_q;
   assign bus.pnf             = pnf_q;
   assign bus.err_count       = err_count_q;
   assign bus.first_err_valid = first_err_valid_q;
   assign bus.first_err_beat  = first_err_beat_q;
   assign bus.overrun         = overrun_q;

endmodule
